// File: rtl/raizing_extratext_cpuif.sv
// CPU bus responder for the extra-text VRAM, line-select RAM and line-scroll RAM.
// Port A is owned by the 68000 access FSM; port B feeds the renderer with 1-cycle registered reads.
module raizing_extratext_cpuif #(
    parameter int unsigned WAIT_STATES  = 1,
    parameter logic [15:0] UNMAPPED_VAL = 16'hFFFF
) (
    input  logic        CLK96,
    input  logic        RESET96_N,
    input  logic        CPU_CS,
    input  logic        CPU_RW,
    input  logic [12:0] CPU_ADDR,
    input  logic        CPU_UDSn,
    input  logic        CPU_LDSn,
    input  logic [15:0] CPU_DOUT,
    output logic [15:0] CPU_DIN,
    output logic        CPU_DTACKn,
    input  logic [11:0] TEXTVRAM_ADDR,
    output logic [15:0] TEXTVRAM_DATA,
    input  logic [7:0]  TEXTSELECT_ADDR,
    output logic [15:0] TEXTSELECT_DATA,
    input  logic [7:0]  TEXTSCROLL_ADDR,
    output logic [15:0] TEXTSCROLL_DATA
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_ACK
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [12:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [1:0]  be_q, be_d;
    logic [15:0] wdata_q, wdata_d;

    logic [15:0] vram_mem   [4096];
    logic [15:0] select_mem [256];
    logic [15:0] scroll_mem [256];

    logic [15:0] vram_a_q, select_a_q, scroll_a_q;
    logic [15:0] vram_b_q, select_b_q, scroll_b_q;

    logic is_vram, is_select, is_scroll, in_access;
    logic we_vram, we_select, we_scroll;
    logic re_vram, re_select, re_scroll;

    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b1;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (CPU_CS && (!CPU_UDSn || !CPU_LDSn)) begin
                    addr_d  = CPU_ADDR;
                    rw_d    = CPU_RW;
                    be_d    = {~CPU_UDSn, ~CPU_LDSn};
                    wdata_d = CPU_DOUT;
                    cnt_d   = 3'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                // The counter value is the number of WAIT cycles still to spend.
                if (!CPU_CS) begin
                    state_d = S_IDLE;
                end else if (cnt_q <= 3'd1) begin
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ACCESS: begin
                state_d = CPU_CS ? S_ACK : S_IDLE;
            end
            S_ACK: begin
                if (!CPU_CS) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign is_vram   = (addr_q[12] == 1'b0);
    assign is_select = (addr_q[12:8] == 5'h10);
    assign is_scroll = (addr_q[12:8] == 5'h11);
    assign in_access = (state_q == S_ACCESS);

    assign we_vram   = in_access && !rw_q && is_vram;
    assign we_select = in_access && !rw_q && is_select;
    assign we_scroll = in_access && !rw_q && is_scroll;
    assign re_vram   = in_access && rw_q && is_vram;
    assign re_select = in_access && rw_q && is_select;
    assign re_scroll = in_access && rw_q && is_scroll;

    // Memory arrays keep their contents across reset.
    always_ff @(posedge CLK96) begin
        if (we_vram) begin
            if (be_q[1]) vram_mem[addr_q[11:0]][15:8] <= wdata_q[15:8];
            if (be_q[0]) vram_mem[addr_q[11:0]][7:0]  <= wdata_q[7:0];
        end
        if (re_vram) vram_a_q <= vram_mem[addr_q[11:0]];
    end

    always_ff @(posedge CLK96) begin
        if (we_select) begin
            if (be_q[1]) select_mem[addr_q[7:0]][15:8] <= wdata_q[15:8];
            if (be_q[0]) select_mem[addr_q[7:0]][7:0]  <= wdata_q[7:0];
        end
        if (re_select) select_a_q <= select_mem[addr_q[7:0]];
    end

    always_ff @(posedge CLK96) begin
        if (we_scroll) begin
            if (be_q[1]) scroll_mem[addr_q[7:0]][15:8] <= wdata_q[15:8];
            if (be_q[0]) scroll_mem[addr_q[7:0]][7:0]  <= wdata_q[7:0];
        end
        if (re_scroll) scroll_a_q <= scroll_mem[addr_q[7:0]];
    end

    // Renderer ports sample the arrays before this edge's CPU write lands (read-first).
    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            vram_b_q   <= '0;
            select_b_q <= '0;
            scroll_b_q <= '0;
        end else begin
            vram_b_q   <= vram_mem[TEXTVRAM_ADDR];
            select_b_q <= select_mem[TEXTSELECT_ADDR];
            scroll_b_q <= scroll_mem[TEXTSCROLL_ADDR];
        end
    end

    assign TEXTVRAM_DATA   = vram_b_q;
    assign TEXTSELECT_DATA = select_b_q;
    assign TEXTSCROLL_DATA = scroll_b_q;

    assign CPU_DTACKn = (state_q != S_ACK);

    always_comb begin
        CPU_DIN = '0;
        if (state_q == S_ACK && rw_q) begin
            if (is_vram)        CPU_DIN = vram_a_q;
            else if (is_select) CPU_DIN = select_a_q;
            else if (is_scroll) CPU_DIN = scroll_a_q;
            else                CPU_DIN = UNMAPPED_VAL;
        end
    end

endmodule
